mem_stage_ctrl: RTL and testbench

//  Consumer side of the EX/MEM pipeline register: executes the MEM stage of the 5-stage MIPS core.

---
 rtl/mem_stage_ctrl_if.sv | 31 +++
 rtl/mem_stage_ctrl.sv | 155 +++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/ready bus between the MEM-stage controller (master) and data memory (slave).
interface mem_stage_ctrl_if #(
  parameter int DATA_W = 32
);

  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ready;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_ready,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_ready,
    output dmem_rdata
  );

endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM stage of the 5-stage MIPS pipe: data-memory handshake, branch resolve, stall and MEM/WB register.
// Optional misaligned-access squash is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage_ctrl #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        WB_i,
  input  logic [2:0]        M_i,
  input  logic [DATA_W-1:0] PC_i,
  input  logic              zero_i,
  input  logic [DATA_W-1:0] ALUresult_i,
  input  logic [DATA_W-1:0] writeData_i,
  input  logic [REG_W-1:0]  writeRegister_i,
  mem_stage_ctrl_if.master  dmem,
  output logic              stall_o,
  output logic              PCSrc_o,
  output logic [DATA_W-1:0] branch_target_o,
  output logic [1:0]        WB_output_o,
  output logic [DATA_W-1:0] readData_output_o,
  output logic [DATA_W-1:0] ALUresult_output_o,
  output logic [REG_W-1:0]  writeRegister_output_o,
  output logic              mem_fault_o
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        wb_q, wb_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [REG_W-1:0]  wreg_q, wreg_d;
  logic              fault_q, fault_d;

  logic memOp;
  logic alignFault;
  logic stallRaw;

  // A simultaneous MemRead+MemWrite is illegal; M[0] alone drives we, so it runs as a store.
  assign memOp = M_i[1] | M_i[0];

`ifdef MEM_ALIGN_CHECK_EN
  assign alignFault = memOp & (ALUresult_i[1:0] != 2'b00);
`else
  assign alignFault = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wb_q    <= 2'b00;
      rdata_q <= '0;
      alu_q   <= '0;
      wreg_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wb_q    <= wb_d;
      rdata_q <= rdata_d;
      alu_q   <= alu_d;
      wreg_q  <= wreg_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    fault_d  = 1'b0;
    stallRaw = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (memOp && !alignFault) begin
          stallRaw = 1'b1;
          req_d    = 1'b1;
          we_d     = M_i[0];
          addr_d   = ALUresult_i;
          wdata_d  = writeData_i;
          state_d  = WAIT;
        end else if (alignFault) begin
          fault_d  = 1'b1;
        end
      end
      WAIT: begin
        // EX/MEM advances on the same edge that retires the access.
        stallRaw = !dmem.dmem_ready;
        if (dmem.dmem_ready) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // MEM/WB: a stall injects a bubble (WB cleared) while the data fields hold their last values.
  always_comb begin
    wb_d    = wb_q;
    rdata_d = rdata_q;
    alu_d   = alu_q;
    wreg_d  = wreg_q;
    if (stallRaw) begin
      wb_d = 2'b00;
    end else begin
      wb_d   = alignFault ? 2'b00 : WB_i;
      alu_d  = ALUresult_i;
      wreg_d = writeRegister_i;
      if ((state_q == WAIT) && dmem.dmem_ready && !we_q) begin
        rdata_d = dmem.dmem_rdata;
      end else begin
        rdata_d = '0;
      end
    end
  end

  // Stall is gated by reset so an abandoned access releases the front of the pipe immediately.
  assign stall_o         = stallRaw & ~reset;
  assign PCSrc_o         = M_i[2] & zero_i;
  assign branch_target_o = PC_i;

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;

  assign WB_output_o            = wb_q;
  assign readData_output_o      = rdata_q;
  assign ALUresult_output_o     = alu_q;
  assign writeRegister_output_o = wreg_q;
  assign mem_fault_o            = fault_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed scenarios plus randomized instruction stream
// checked every cycle against a transaction-level model.
module tb_mem_stage_ctrl;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [1:0]        wbIn = '0;
  logic [2:0]        mIn = '0;
  logic [DATA_W-1:0] pcIn = '0;
  logic              zeroIn = 1'b0;
  logic [DATA_W-1:0] aluIn = '0;
  logic [DATA_W-1:0] wdataIn = '0;
  logic [REG_W-1:0]  wregIn = '0;
  logic              stall, pcSrc, memFault;
  logic [DATA_W-1:0] branchTarget, readDataOut, aluOut;
  logic [1:0]        wbOut;
  logic [REG_W-1:0]  wregOut;

  int nChecks = 0;
  int nErrors = 0;
  bit checkEn = 1'b0;

  mem_stage_ctrl_if #(.DATA_W(DATA_W)) dmem ();

  mem_stage_ctrl #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .WB_i                   (wbIn),
    .M_i                    (mIn),
    .PC_i                   (pcIn),
    .zero_i                 (zeroIn),
    .ALUresult_i            (aluIn),
    .writeData_i            (wdataIn),
    .writeRegister_i        (wregIn),
    .dmem                   (dmem.master),
    .stall_o                (stall),
    .PCSrc_o                (pcSrc),
    .branch_target_o        (branchTarget),
    .WB_output_o            (wbOut),
    .readData_output_o      (readDataOut),
    .ALUresult_output_o     (aluOut),
    .writeRegister_output_o (wregOut),
    .mem_fault_o            (memFault)
  );

  always #5 clk = ~clk;

  // Transaction-level model: is an access outstanding, what did it capture, what MEM/WB must hold.
  logic              mInAccess = 1'b0;
  logic              mWe = 1'b0;
  logic [DATA_W-1:0] mAddr = '0, mWdata = '0, mRd = '0, mAlu = '0;
  logic [1:0]        mWb = '0;
  logic [REG_W-1:0]  mReg = '0;
  logic              mFault = 1'b0;

  function automatic logic misalF();
    return ALIGN && (mIn[1] | mIn[0]) && (aluIn[1:0] != 2'b00);
  endfunction

  function automatic logic expStallF();
    if (reset) return 1'b0;
    if (mInAccess) return !dmem.dmem_ready;
    return (mIn[1] | mIn[0]) && !misalF();
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mInAccess <= 1'b0;
      mWb       <= 2'b00;
      mRd       <= '0;
      mAlu      <= '0;
      mReg      <= '0;
      mFault    <= 1'b0;
    end else begin
      if (expStallF()) begin
        mWb <= 2'b00;
      end else begin
        mWb  <= misalF() ? 2'b00 : wbIn;
        mAlu <= aluIn;
        mReg <= wregIn;
        mRd  <= (mInAccess && dmem.dmem_ready && !mWe) ? dmem.dmem_rdata : '0;
      end
      mFault <= !mInAccess && misalF();
      if (mInAccess) begin
        if (dmem.dmem_ready) mInAccess <= 1'b0;
      end else if ((mIn[1] | mIn[0]) && !misalF()) begin
        mInAccess <= 1'b1;
        mAddr     <= aluIn;
        mWe       <= mIn[0];
        mWdata    <= wdataIn;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                             input logic [DATA_W-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle compare against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("stall", 32'(stall), 32'(expStallF()));
      checkOutput("PCSrc", 32'(pcSrc), 32'(mIn[2] & zeroIn));
      checkOutput("branch_target", branchTarget, pcIn);
      checkOutput("dmem_req", 32'(dmem.dmem_req), 32'(mInAccess));
      if (mInAccess) begin
        checkOutput("dmem_we", 32'(dmem.dmem_we), 32'(mWe));
        checkOutput("dmem_addr", dmem.dmem_addr, mAddr);
        checkOutput("dmem_wdata", dmem.dmem_wdata, mWdata);
      end
      checkOutput("WB_output", 32'(wbOut), 32'(mWb));
      checkOutput("readData_output", readDataOut, mRd);
      checkOutput("ALUresult_output", aluOut, mAlu);
      checkOutput("writeRegister_output", 32'(wregOut), 32'(mReg));
      checkOutput("mem_fault", 32'(memFault), 32'(mFault));
    end
  end

  task automatic applyStimulus(input logic [1:0] wb, input logic [2:0] m, input logic [DATA_W-1:0] pc,
                               input logic z, input logic [DATA_W-1:0] alu,
                               input logic [DATA_W-1:0] wd, input logic [REG_W-1:0] wr);
    wbIn = wb; mIn = m; pcIn = pc; zeroIn = z; aluIn = alu; wdataIn = wd; wregIn = wr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit advance;
    logic [DATA_W-1:0] addr;
    int kind;
    dmem.dmem_ready = 1'b0;
    dmem.dmem_rdata = '0;
    #1 reset = 1'b1;
    checkEn = 1'b1;
    #1;
    checkOutput("reset WB_output", 32'(wbOut), 32'd0);
    checkOutput("reset dmem_req", 32'(dmem.dmem_req), 32'd0);
    checkOutput("reset readData", readDataOut, 32'd0);
    checkOutput("reset mem_fault", 32'(memFault), 32'd0);
    tick();
    tick();
    reset = 1'b0;

    // R-type passes straight through.
    applyStimulus(2'b10, 3'b000, '0, 1'b0, 32'h5, '0, 5'd3);
    @(negedge clk);
    checkOutput("rtype stall", 32'(stall), 32'd0);
    tick();
    @(negedge clk);
    checkOutput("rtype WB_output", 32'(wbOut), 32'h2);
    checkOutput("rtype ALUresult", aluOut, 32'h5);
    checkOutput("rtype wreg", 32'(wregOut), 32'd3);
    checkOutput("rtype req", 32'(dmem.dmem_req), 32'd0);

    // Load completing on the third WAIT cycle.
    tick();
    applyStimulus(2'b11, 3'b010, '0, 1'b0, 32'h100, '0, 5'd7);
    @(negedge clk);
    checkOutput("load idle stall", 32'(stall), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      dmem.dmem_ready = (i == 2);
      dmem.dmem_rdata = (i == 2) ? 32'hDEAD_BEEF : 32'h0;
      @(negedge clk);
      checkOutput("load req", 32'(dmem.dmem_req), 32'd1);
      checkOutput("load we", 32'(dmem.dmem_we), 32'd0);
      checkOutput("load addr", dmem.dmem_addr, 32'h100);
      checkOutput("load bubble", 32'(wbOut), 32'd0);
      checkOutput("load wait stall", 32'(stall), (i == 2) ? 32'd0 : 32'd1);
    end
    tick();
    applyStimulus(2'b00, 3'b000, '0, 1'b0, 32'h9, '0, 5'd1);
    dmem.dmem_ready = 1'b0;
    @(negedge clk);
    checkOutput("load readData", readDataOut, 32'hDEAD_BEEF);
    checkOutput("load WB_output", 32'(wbOut), 32'h3);
    checkOutput("load wreg", 32'(wregOut), 32'd7);

    // Store completing in the first WAIT cycle; ready in IDLE must be ignored.
    tick();
    applyStimulus(2'b00, 3'b001, '0, 1'b0, 32'h40, 32'h1234, 5'd0);
    dmem.dmem_ready = 1'b1;
    @(negedge clk);
    checkOutput("store idle stall", 32'(stall), 32'd1);
    tick();
    @(negedge clk);
    checkOutput("store we", 32'(dmem.dmem_we), 32'd1);
    checkOutput("store wdata", dmem.dmem_wdata, 32'h1234);
    checkOutput("store wait stall", 32'(stall), 32'd0);
    tick();
    applyStimulus(2'b10, 3'b000, '0, 1'b0, 32'h1, '0, 5'd2);
    dmem.dmem_ready = 1'b0;
    @(negedge clk);
    checkOutput("store readData", readDataOut, 32'd0);
    checkOutput("store req done", 32'(dmem.dmem_req), 32'd0);

    // Branch resolves combinationally.
    tick();
    applyStimulus(2'b00, 3'b100, 32'h200, 1'b1, 32'h0, '0, 5'd0);
    #1;
    checkOutput("branch PCSrc", 32'(pcSrc), 32'd1);
    checkOutput("branch target", branchTarget, 32'h200);
    checkOutput("branch stall", 32'(stall), 32'd0);
    zeroIn = 1'b0;
    #1;
    checkOutput("branch not taken", 32'(pcSrc), 32'd0);

    // Reset in WAIT abandons the access without a clock edge.
    tick();
    applyStimulus(2'b11, 3'b010, '0, 1'b0, 32'h80, '0, 5'd4);
    tick();
    @(negedge clk);
    checkOutput("rst-wait req before", 32'(dmem.dmem_req), 32'd1);
    #1 reset = 1'b1;
    #1;
    checkOutput("rst-wait req", 32'(dmem.dmem_req), 32'd0);
    checkOutput("rst-wait stall", 32'(stall), 32'd0);
    checkOutput("rst-wait WB_output", 32'(wbOut), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst-reissue stall", 32'(stall), 32'd1);
    tick();
    dmem.dmem_ready = 1'b1;
    dmem.dmem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    checkOutput("rst-reissue addr", dmem.dmem_addr, 32'h80);
    tick();
    applyStimulus(2'b00, 3'b000, '0, 1'b0, 32'h0, '0, 5'd0);
    dmem.dmem_ready = 1'b0;
    @(negedge clk);
    checkOutput("rst-reissue readData", readDataOut, 32'hCAFE_F00D);
    checkOutput("rst-reissue WB_output", 32'(wbOut), 32'h3);

    // Misaligned load.
    tick();
    applyStimulus(2'b11, 3'b010, '0, 1'b0, 32'h102, '0, 5'd5);
`ifdef MEM_ALIGN_CHECK_EN
    @(negedge clk);
    checkOutput("misal stall", 32'(stall), 32'd0);
    tick();
    applyStimulus(2'b00, 3'b000, '0, 1'b0, 32'h0, '0, 5'd0);
    @(negedge clk);
    checkOutput("misal fault", 32'(memFault), 32'd1);
    checkOutput("misal WB_output", 32'(wbOut), 32'd0);
    checkOutput("misal req", 32'(dmem.dmem_req), 32'd0);
    tick();
    @(negedge clk);
    checkOutput("misal fault pulse", 32'(memFault), 32'd0);
`else
    @(negedge clk);
    checkOutput("misal stall", 32'(stall), 32'd1);
    tick();
    dmem.dmem_ready = 1'b1;
    @(negedge clk);
    checkOutput("misal req", 32'(dmem.dmem_req), 32'd1);
    checkOutput("misal addr", dmem.dmem_addr, 32'h102);
    tick();
    applyStimulus(2'b00, 3'b000, '0, 1'b0, 32'h0, '0, 5'd0);
    dmem.dmem_ready = 1'b0;
    @(negedge clk);
    checkOutput("misal fault", 32'(memFault), 32'd0);
`endif

    // Randomized instruction stream; a new instruction enters only when the stage advances.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      advance = !expStallF();
      tick();
      if (advance) begin
        kind = int'($urandom_range(0, 4));
        addr = $urandom;
        if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
        applyStimulus(2'($urandom), (kind == 1) ? 3'b010 : (kind == 2) ? 3'b001 :
                      (kind == 3) ? 3'b100 : (kind == 4) ? 3'b011 : 3'b000,
                      $urandom, 1'($urandom), addr, $urandom, 5'($urandom));
      end
      dmem.dmem_ready = ($urandom_range(0, 2) == 0);
      dmem.dmem_rdata = $urandom;
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
